// File: rtl/multiplicador_pkg.sv
// Shared constants for the shift-and-add multiplier: FSM state encoding and default operand width.
// Latency: n/a (constants only).
// Backpressure: n/a (constants only).
package multiplicador_pkg;

   localparam int DEF_WIDTH = 8;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_CHECK = 3'd1;
   localparam logic [2:0] ST_ADD   = 3'd2;
   localparam logic [2:0] ST_SHIFT = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/mult_shift_add_dp.sv
// Shift-and-add datapath: shifted multiplicand A, shifted multiplier B, accumulator, B==0 detect.
// Latency: every control strobe takes effect on the next rising edge of clk.
// Backpressure: none; the controlling FSM raises at most one strobe per cycle.
module mult_shift_add_dp
   import multiplicador_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_load,
   input  logic               i_add,
   input  logic               i_shift,
   input  logic [WIDTH-1:0]   i_mr_mag,
   input  logic [WIDTH-1:0]   i_md_mag,
   output logic [2*WIDTH-1:0] o_acc,
   output logic               o_b_zero,
   output logic               o_b_lsb
);

   logic [2*WIDTH-1:0] r_a;
   logic [WIDTH-1:0]   r_b;
   logic [2*WIDTH-1:0] r_acc;

   // Load operands, accumulate A, or shift A left and B right, as strobed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a   <= '0;
         r_b   <= '0;
         r_acc <= '0;
      end else if (i_load) begin
         r_a   <= {{WIDTH{1'b0}}, i_md_mag};
         r_b   <= i_mr_mag;
         r_acc <= '0;
      end else if (i_add) begin
         r_acc <= r_acc + r_a;
      end else if (i_shift) begin
         r_a   <= r_a << 1;
         r_b   <= r_b >> 1;
      end
   end

   assign o_acc    = r_acc;
   assign o_b_zero = (r_b == '0);
   assign o_b_lsb  = r_b[0];

endmodule

// File: rtl/multiplicador_n.sv
// Sequential shift-and-add multiplier; optional two's-complement mode under MULT_SIGNED_EN.
// Latency: 1 + sum(2 + MR[i]) edges over the bits of |MR| up to its top 1 (1 when MR=0).
// Backpressure: init is only sampled in IDLE; requests while busy or in DONE are dropped.
module multiplicador_n
   import multiplicador_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               init,
   input  logic [WIDTH-1:0]   MR,
   input  logic [WIDTH-1:0]   MD,
`ifdef MULT_SIGNED_EN
   input  logic               sgn,
`endif
   output logic [2*WIDTH-1:0] pp,
   output logic               done,
   output logic               busy
);

   logic [2:0]         r_state;
   logic [2:0]         w_state_nxt;
   logic [2*WIDTH-1:0] r_pp;
   logic               r_done;
   logic [WIDTH-1:0]   w_mr_mag;
   logic [WIDTH-1:0]   w_md_mag;
   logic [2*WIDTH-1:0] w_acc;
   logic [2*WIDTH-1:0] w_result;
   logic               w_b_zero;
   logic               w_b_lsb;
   logic               w_load;
   logic               w_add;
   logic               w_shift;
   logic               w_finish;

   assign w_load   = (r_state == ST_IDLE) && init;
   assign w_add    = (r_state == ST_ADD);
   assign w_shift  = (r_state == ST_SHIFT);
   assign w_finish = (r_state == ST_CHECK) && w_b_zero;

`ifdef MULT_SIGNED_EN
   logic r_neg;

   // Magnitudes feed the unsigned datapath; -2^(WIDTH-1) maps to itself, read as unsigned.
   assign w_mr_mag = (sgn && MR[WIDTH-1]) ? -MR : MR;
   assign w_md_mag = (sgn && MD[WIDTH-1]) ? -MD : MD;
   assign w_result = r_neg ? -w_acc : w_acc;

   // Latch the result sign together with the operands.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_neg <= 1'b0;
      end else if (w_load) begin
         r_neg <= sgn && (MR[WIDTH-1] ^ MD[WIDTH-1]);
      end
   end
`else
   assign w_mr_mag = MR;
   assign w_md_mag = MD;
   assign w_result = w_acc;
`endif

   mult_shift_add_dp #(
      .WIDTH    (WIDTH)
   ) u_dp (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_load   (w_load),
      .i_add    (w_add),
      .i_shift  (w_shift),
      .i_mr_mag (w_mr_mag),
      .i_md_mag (w_md_mag),
      .o_acc    (w_acc),
      .o_b_zero (w_b_zero),
      .o_b_lsb  (w_b_lsb)
   );

   // Next-state decode: walk B one bit per CHECK/[ADD]/SHIFT round until it empties.
   always_comb begin
      w_state_nxt = ST_IDLE;
      case (r_state)
         ST_IDLE:  w_state_nxt = init ? ST_CHECK : ST_IDLE;
         ST_CHECK: begin
            if (w_b_zero) begin
               w_state_nxt = ST_DONE;
            end else if (w_b_lsb) begin
               w_state_nxt = ST_ADD;
            end else begin
               w_state_nxt = ST_SHIFT;
            end
         end
         ST_ADD:   w_state_nxt = ST_SHIFT;
         ST_SHIFT: w_state_nxt = ST_CHECK;
         ST_DONE:  w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Capture the product and pulse done on the CHECK->DONE edge; pp holds otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pp   <= '0;
         r_done <= 1'b0;
      end else begin
         r_done <= w_finish;
         if (w_finish) begin
            r_pp <= w_result;
         end
      end
   end

   assign pp   = r_pp;
   assign done = r_done;
   assign busy = (r_state == ST_CHECK) || (r_state == ST_ADD) || (r_state == ST_SHIFT);

endmodule

// File: tb/tb_multiplicador_n.sv
// Directed bench for multiplicador_n (WIDTH=8) with a queue of expected product/latency pairs.
// Latency: each operation is followed until done, bounded by a cycle budget.
// Backpressure: init pulses while busy must be ignored; held init restarts from IDLE.
module tb_multiplicador_n;

   logic        clk;
   logic        rst_n;
   logic        init;
   logic [7:0]  MR;
   logic [7:0]  MD;
   logic        sgn_t;
   logic [15:0] pp;
   logic        done;
   logic        busy;

   typedef struct {
      logic [15:0] pp;
      int          lat;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks;
   int   n_err;

   multiplicador_n #(
      .WIDTH (8)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .init  (init),
      .MR    (MR),
      .MD    (MD),
`ifdef MULT_SIGNED_EN
      .sgn   (sgn_t),
`endif
      .pp    (pp),
      .done  (done),
      .busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] model_pp(input logic [7:0] mr, input logic [7:0] md, input logic sg);
      logic [15:0] r;
      if (sg) r = 16'($signed(mr) * $signed(md));
      else    r = 16'(mr) * 16'(md);
      return r;
   endfunction

   function automatic int model_lat(input logic [7:0] mr, input logic sg);
      logic [7:0] m;
      int         lat;
      m   = (sg && mr[7]) ? 8'(-mr) : mr;
      lat = 1;
      while (m != 8'd0) begin
         lat = lat + 2 + int'(m[0]);
         m   = m >> 1;
      end
      return lat;
   endfunction

   task automatic run_op(input string tag, input logic [7:0] mr, input logic [7:0] md,
                         input logic sg, input bit noisy);
      int   cyc;
      bit   busy_ok;
      exp_t e;
      @(negedge clk);
      MR    = mr;
      MD    = md;
      sgn_t = sg;
      init  = 1'b1;
      exp_q.push_back('{pp: model_pp(mr, md, sg), lat: model_lat(mr, sg)});
      @(posedge clk);
      #1;
      init    = 1'b0;
      busy_ok = (busy === 1'b1);
      cyc     = 0;
      while (cyc < 200) begin
         @(posedge clk);
         cyc++;
         #1;
         if (done === 1'b1) break;
         if (busy !== 1'b1) busy_ok = 1'b0;
         if (noisy) init = ~init;
      end
      init = 1'b0;
      e = exp_q.pop_front();
      chk({tag, "_latency"}, 32'(cyc), 32'(e.lat));
      chk({tag, "_pp"}, 32'(pp), 32'(e.pp));
      chk({tag, "_busy_during"}, 32'(busy_ok), 32'd1);
      chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
   endtask

   initial begin
      int   cyc;
      bit   quiet;
      exp_t e;
      n_checks = 0;
      n_err    = 0;
      rst_n    = 1'b0;
      init     = 1'b0;
      MR       = 8'd0;
      MD       = 8'd0;
      sgn_t    = 1'b0;

      #2;
      chk("reset_pp", 32'(pp), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      run_op("mr_zero", 8'h00, 8'h5A, 1'b0, 1'b0);
      run_op("ff_ff", 8'hFF, 8'hFF, 1'b0, 1'b0);
      run_op("noisy_3x7", 8'd3, 8'd7, 1'b0, 1'b1);

      // No restart after the noisy run: stays idle with no further done.
      quiet = 1'b1;
      repeat (6) begin
         @(posedge clk);
         #1;
         if (done !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
      end
      chk("noisy_no_restart", 32'(quiet), 32'd1);
      chk("noisy_pp_held", 32'(pp), 32'd21);

      // init held high: finish, one cycle in IDLE, then restart.
      @(negedge clk);
      MR   = 8'd1;
      MD   = 8'd3;
      init = 1'b1;
      exp_q.push_back('{pp: model_pp(8'd1, 8'd3, 1'b0), lat: model_lat(8'd1, 1'b0)});
      @(posedge clk);
      cyc = 0;
      while (cyc < 200) begin
         @(posedge clk);
         cyc++;
         #1;
         if (done === 1'b1) break;
      end
      e = exp_q.pop_front();
      chk("held_latency", 32'(cyc), 32'(e.lat));
      chk("held_pp", 32'(pp), 32'(e.pp));
      @(posedge clk);
      #1;
      chk("held_idle_busy", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      chk("held_restart_busy", 32'(busy), 32'd1);
      init = 1'b0;
      cyc  = 0;
      while (cyc < 200) begin
         @(posedge clk);
         cyc++;
         #1;
         if (done === 1'b1) break;
      end
      chk("held_restart_done", 32'(done), 32'd1);

      // Asynchronous reset mid-operation.
      @(negedge clk);
      MR   = 8'hFF;
      MD   = 8'hFF;
      init = 1'b1;
      @(posedge clk);
      #1;
      init = 1'b0;
      repeat (5) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("abort_pp", 32'(pp), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      quiet = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
         if (done !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
         if (done !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
      end
      chk("abort_no_done", 32'(quiet), 32'd1);
      run_op("after_reset_2x9", 8'd2, 8'd9, 1'b0, 1'b0);
      chk("after_reset_pp18", 32'(pp), 32'd18);

`ifdef MULT_SIGNED_EN
      run_op("signed_m3x5", 8'hFD, 8'd5, 1'b1, 1'b0);
      chk("signed_m3x5_val", 32'(pp), 32'h0000FFF1);
      run_op("signed_80x80", 8'h80, 8'h80, 1'b1, 1'b0);
      chk("signed_80x80_val", 32'(pp), 32'h00004000);
      run_op("unsigned_in_signed_build", 8'hFD, 8'd5, 1'b0, 1'b0);
`endif

      run_op("a5x3c", 8'hA5, 8'h3C, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
